// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmit engine among NUM_REQ byte-level requesters.
// A round-robin arbiter picks one requester, latches its byte and parity mode,
// pulses the engine's start input and then follows the engine's busy flag
// through one frame. When the frame ends, the winner gets a one-cycle ack
// (with err_o set if the engine never went busy), and a fixed idle gap is
// enforced before the next frame can start.
//
// Ports
//   clk_i       in   1           system clock
//   resetn_i    in   1           asynchronous active-low reset
//   req_i       in   NUM_REQ     level request per requester, held until ack
//   data_i      in   NUM_REQ*8   byte per requester, slice k = [8k+7:8k]
//   ctrl_i      in   NUM_REQ*3   parity mode per requester, slice k = [3k+2:3k]
//   ack_o       out  NUM_REQ     one-cycle pulse to the served requester
//   err_o       out  1           pulses with ack_o when the engine never went busy
//   grant_o     out  NUM_REQ     one-hot owner, held from ARB exit through ACK
//   tx_start_o  out  1           one-cycle start pulse to the engine
//   tx_data_o   out  8           byte to the engine, stable until the next load
//   tx_ctrl_o   out  3           parity mode to the engine, stable with tx_data_o
//   tx_busy_i   in   1           engine busy flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,   // 2..8
  parameter int START_TIMEOUT = 16,  // >= 2
  parameter int GAP_CYCLES    = 2    // 0..15
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] data_i,
  input  logic [NUM_REQ*3-1:0] ctrl_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 err_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  output logic [2:0]           tx_ctrl_o,
  input  logic                 tx_busy_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK,
    S_GAP
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;      // first index searched in the next arbitration
  logic [TO_W-1:0]  to_cnt;   // cycles spent waiting for the engine to go busy
  logic [3:0]       gap_cnt;  // remaining idle cycles after an ack

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set request at or after ptr, wrapping past the top.
  // ---------------------------------------------------------------------------
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] ptr_next;

  // NOTE: every combinational output gets a default before the loop so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  // Winner's one-hot code and its data/ctrl slices, selected with constant
  // slice bounds.
  logic [NUM_REQ-1:0] win_oh;
  logic [7:0]         sel_data;
  logic [2:0]         sel_ctrl;

  always_comb begin
    win_oh   = '0;
    sel_data = '0;
    sel_ctrl = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        win_oh[k] = 1'b1;
        sel_data  = data_i[8*k +: 8];
        sel_ctrl  = ctrl_i[3*k +: 3];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered and are set on the transition into
  // the state that owns them, so each one is valid for exactly that state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge regardless of order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state      <= S_IDLE;
      ptr        <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      ack_o      <= '0;
      err_o      <= 1'b0;
      grant_o    <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
      tx_ctrl_o  <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_i) state <= S_ARB;
        end

        // A request that vanished between IDLE and ARB produces no frame.
        S_ARB: begin
          if (win_found) begin
            grant_o    <= win_oh;
            tx_data_o  <= sel_data;
            tx_ctrl_o  <= sel_ctrl;
            ptr        <= ptr_next;
            tx_start_o <= 1'b1;
            state      <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end

        S_LOAD: begin
          tx_start_o <= 1'b0;
          to_cnt     <= '0;
          state      <= S_WAIT_BUSY;
        end

        // Busy is checked before the timeout, so busy arriving on the last
        // allowed cycle still counts. A busy flag that is already high
        // (stale) is taken as the frame having started.
        S_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
            ack_o <= grant_o;
            err_o <= 1'b1;
            state <= S_ACK;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy_i) begin
            ack_o <= grant_o;
            err_o <= 1'b0;
            state <= S_ACK;
          end
        end

        // err_o doubles as the error flag; it is only meaningful during ACK.
        S_ACK: begin
          ack_o   <= '0;
          err_o   <= 1'b0;
          grant_o <= '0;
          if (GAP_CYCLES == 0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= 4'(GAP_CYCLES - 1);
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
